// File: rtl/aio20_pkg.sv
// Shared types and constants for the AIO20 conversion sequencer.
// Holds the sequencer state encoding and the read-frame layout.
package aio20_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CNVT     = 3'd1,
        WAIT_INT = 3'd2,
        SETUP    = 3'd3,
        SHIFT    = 3'd4,
        HOLD     = 3'd5,
        DONE     = 3'd6
    } aio20_state_e;

    localparam logic [3:0] AIO20_CMD_READ   = 4'b1000;
    localparam int         AIO20_FRAME_BITS = 24;
    localparam int         AIO20_DATA_BITS  = 16;

    // Read command frame: opcode, channel, then 16 dummy bits clocked during the response.
    function automatic logic [AIO20_FRAME_BITS-1:0] aio20_read_frame(input logic [3:0] ch);
        return {AIO20_CMD_READ, ch, 16'h0000};
    endfunction

endpackage

// File: rtl/aio20_spi_frame.sv
// One 24-bit SPI mode-0 read frame: setup phase with NSS low, then 24 MSB-first bits.
// A start pulse launches the frame; done pulses in the cycle NSS returns high.
module aio20_spi_frame
    import aio20_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [3:0]                 ch,
    input  logic                       miso,
    output logic                       sclk,
    output logic                       nss,
    output logic                       mosi,
    output logic                       in_shift,
    output logic                       done,
    output logic [AIO20_DATA_BITS-1:0] rx
);

    localparam int              DW       = $clog2(CLK_DIV) + 1;
    localparam logic [DW-1:0]   DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [4:0]      BIT_LAST = 5'(AIO20_FRAME_BITS - 1);

    logic                        active_r;
    logic                        setup_r;
    logic                        sclk_r;
    logic                        nss_r;
    logic                        mosi_r;
    logic [DW-1:0]               div_cnt_r;
    logic [4:0]                  bit_cnt_r;
    logic [AIO20_FRAME_BITS-1:0] tx_sr_r;
    logic [AIO20_DATA_BITS-1:0]  rx_sr_r;
    logic [AIO20_FRAME_BITS-1:0] frame_s;
    logic                        phase_end_s;

    // Frame image and end-of-phase decode.
    always_comb begin
        frame_s     = aio20_read_frame(ch);
        phase_end_s = (div_cnt_r == DIV_LAST);
        done        = active_r & ~setup_r & sclk_r & phase_end_s & (bit_cnt_r == BIT_LAST);
    end

    // SCLK divider, bit counter and shift registers; reset parks the bus idle at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_r  <= 1'b0;
            setup_r   <= 1'b0;
            sclk_r    <= 1'b0;
            nss_r     <= 1'b1;
            mosi_r    <= 1'b0;
            div_cnt_r <= '0;
            bit_cnt_r <= 5'd0;
            tx_sr_r   <= '0;
            rx_sr_r   <= '0;
        end else if (!active_r) begin
            if (start) begin
                active_r  <= 1'b1;
                setup_r   <= 1'b1;
                nss_r     <= 1'b0;
                sclk_r    <= 1'b0;
                div_cnt_r <= '0;
                bit_cnt_r <= 5'd0;
                tx_sr_r   <= frame_s;
                mosi_r    <= frame_s[AIO20_FRAME_BITS-1];
            end
        end else if (!phase_end_s) begin
            div_cnt_r <= div_cnt_r + DW'(1);
        end else begin
            div_cnt_r <= '0;
            if (setup_r) begin
                setup_r <= 1'b0;
            end else if (!sclk_r) begin
                // Rising SCLK: the slave has had a full low phase to settle MISO.
                sclk_r  <= 1'b1;
                rx_sr_r <= {rx_sr_r[AIO20_DATA_BITS-2:0], miso};
            end else begin
                sclk_r <= 1'b0;
                if (bit_cnt_r == BIT_LAST) begin
                    active_r <= 1'b0;
                    nss_r    <= 1'b1;
                    mosi_r   <= 1'b0;
                end else begin
                    bit_cnt_r <= bit_cnt_r + 5'd1;
                    tx_sr_r   <= {tx_sr_r[AIO20_FRAME_BITS-2:0], 1'b0};
                    mosi_r    <= tx_sr_r[AIO20_FRAME_BITS-2];
                end
            end
        end
    end

    assign sclk     = sclk_r;
    assign nss      = nss_r;
    assign mosi     = mosi_r;
    assign in_shift = active_r & ~setup_r;
    assign rx       = rx_sr_r;

endmodule

// File: rtl/aio20_scan_ctrl.sv
// Round-robin AIO20 conversion sequencer: CNVT strobe, wait for INT, SPI read, publish sample.
// Owns the FSM, CNVT timer, INT synchronizer, INT timeout and channel counter.
module aio20_scan_ctrl
    import aio20_pkg::*;
#(
    parameter int CLK_DIV     = 4,
    parameter int CNVT_WIDTH  = 8,
    parameter int INT_TIMEOUT = 1023,
    parameter int N_CH        = 8
) (
    input  logic        AIO20_CLK,
    input  logic        AIO20_RST,
    input  logic        AIO20_EN,
    output logic        AIO20_SPI_CLK_OUT,
    output logic        AIO20_SPI_MOSI_OUT,
    input  logic        AIO20_SPI_MISO_IN,
    output logic        AIO20_SPI_NSS_OUT,
    input  logic        AIO20_SPI_INT_IN,
    output logic        AIO20_CNVT_OUT,
    output logic [15:0] AIO20_DATA,
    output logic [3:0]  AIO20_DATA_CH,
    output logic        AIO20_DATA_VALID,
    output logic        AIO20_TIMEOUT_ERR,
    output logic        AIO20_BUSY
);

    localparam int            CW        = $clog2(CNVT_WIDTH) + 1;
    localparam int            TW        = $clog2(INT_TIMEOUT) + 1;
    localparam int            HW        = $clog2(CLK_DIV) + 1;
    localparam logic [CW-1:0] CNVT_LAST = CW'(CNVT_WIDTH - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(INT_TIMEOUT);
    localparam logic [HW-1:0] HOLD_LAST = HW'(CLK_DIV - 1);
    localparam logic [3:0]    CH_LAST   = 4'(N_CH - 1);

    aio20_state_e                state_r;
    aio20_state_e                state_nxt_s;
    logic [CW-1:0]               cnvt_cnt_r;
    logic [TW-1:0]               tmo_cnt_r;
    logic [HW-1:0]               hold_cnt_r;
    logic                        int_meta_r;
    logic                        int_sync_r;
    logic [3:0]                  ch_r;
    logic [3:0]                  ch_nxt_s;
    logic                        frame_ok_r;
    logic [15:0]                 data_r;
    logic [3:0]                  data_ch_r;
    logic                        valid_r;
    logic                        tmo_err_r;
    logic                        busy_r;
    logic                        cnvt_r;
    logic                        start_s;
    logic                        tmo_hit_s;
    logic                        done_s;
    logic                        in_shift_s;
    logic [AIO20_DATA_BITS-1:0]  rx_s;

    aio20_spi_frame #(
        .CLK_DIV (CLK_DIV)
    ) u_spi_frame (
        .clk      (AIO20_CLK),
        .rst      (AIO20_RST),
        .start    (start_s),
        .ch       (ch_r),
        .miso     (AIO20_SPI_MISO_IN),
        .sclk     (AIO20_SPI_CLK_OUT),
        .nss      (AIO20_SPI_NSS_OUT),
        .mosi     (AIO20_SPI_MOSI_OUT),
        .in_shift (in_shift_s),
        .done     (done_s),
        .rx       (rx_s)
    );

    // Next-state decode; a synchronized INT is checked before the timeout so INT wins a tie.
    always_comb begin
        state_nxt_s = state_r;
        start_s     = 1'b0;
        tmo_hit_s   = 1'b0;
        ch_nxt_s    = (ch_r == CH_LAST) ? 4'd0 : ch_r + 4'd1;
        case (state_r)
            IDLE: begin
                if (AIO20_EN) state_nxt_s = CNVT;
                else          state_nxt_s = IDLE;
            end
            CNVT: begin
                if (cnvt_cnt_r == CNVT_LAST) state_nxt_s = WAIT_INT;
                else                         state_nxt_s = CNVT;
            end
            WAIT_INT: begin
                if (!int_sync_r) begin
                    state_nxt_s = SETUP;
                    start_s     = 1'b1;
                end else if (tmo_cnt_r == TMO_LAST) begin
                    state_nxt_s = HOLD;
                    tmo_hit_s   = 1'b1;
                end else begin
                    state_nxt_s = WAIT_INT;
                end
            end
            SETUP: begin
                if (in_shift_s) state_nxt_s = SHIFT;
                else            state_nxt_s = SETUP;
            end
            SHIFT: begin
                if (done_s) state_nxt_s = HOLD;
                else        state_nxt_s = SHIFT;
            end
            HOLD: begin
                if (hold_cnt_r == HOLD_LAST) state_nxt_s = DONE;
                else                         state_nxt_s = HOLD;
            end
            DONE: begin
                if (AIO20_EN) state_nxt_s = CNVT;
                else          state_nxt_s = IDLE;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, timers, INT synchronizer, channel counter and registered host outputs.
    always_ff @(posedge AIO20_CLK or posedge AIO20_RST) begin
        if (AIO20_RST) begin
            state_r    <= IDLE;
            cnvt_cnt_r <= '0;
            tmo_cnt_r  <= '0;
            hold_cnt_r <= '0;
            int_meta_r <= 1'b1;
            int_sync_r <= 1'b1;
            ch_r       <= 4'd0;
            frame_ok_r <= 1'b0;
            data_r     <= 16'h0000;
            data_ch_r  <= 4'd0;
            valid_r    <= 1'b0;
            tmo_err_r  <= 1'b0;
            busy_r     <= 1'b0;
            cnvt_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            int_meta_r <= AIO20_SPI_INT_IN;
            int_sync_r <= int_meta_r;
            cnvt_r     <= (state_r == CNVT);
            busy_r     <= (state_nxt_s != IDLE);
            tmo_err_r  <= tmo_hit_s;
            valid_r    <= (state_r == DONE) && frame_ok_r;

            if (state_r == CNVT) cnvt_cnt_r <= cnvt_cnt_r + CW'(1);
            else                 cnvt_cnt_r <= '0;

            // Timeout counter saturates so a stalled module can never alias back to zero.
            if (state_r == CNVT)                                  tmo_cnt_r <= '0;
            else if (state_r == WAIT_INT && tmo_cnt_r != TMO_LAST) tmo_cnt_r <= tmo_cnt_r + TW'(1);

            if (state_r == HOLD) hold_cnt_r <= hold_cnt_r + HW'(1);
            else                 hold_cnt_r <= '0;

            if (state_r == SHIFT && done_s) frame_ok_r <= 1'b1;
            else if (state_r == DONE)       frame_ok_r <= 1'b0;

            if (tmo_hit_s) begin
                ch_r <= ch_nxt_s;
            end else if (state_r == DONE && frame_ok_r) begin
                data_r    <= rx_s;
                data_ch_r <= ch_r;
                ch_r      <= ch_nxt_s;
            end
        end
    end

    assign AIO20_CNVT_OUT    = cnvt_r;
    assign AIO20_DATA        = data_r;
    assign AIO20_DATA_CH     = data_ch_r;
    assign AIO20_DATA_VALID  = valid_r;
    assign AIO20_TIMEOUT_ERR = tmo_err_r;
    assign AIO20_BUSY        = busy_r;

endmodule

// File: tb/tb_aio20_scan_ctrl.sv
// Directed bench for aio20_scan_ctrl with a small AIO20 slave model (INT responder + SPI slave).
// The slave answers each read with slave_base + requested channel.
module tb_aio20_scan_ctrl;

    localparam int CLK_DIV     = 2;
    localparam int CNVT_WIDTH  = 8;
    localparam int INT_TIMEOUT = 15;
    localparam int N_CH        = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        miso;
    logic        int_n;
    logic        sclk;
    logic        mosi;
    logic        nss;
    logic        cnvt;
    logic [15:0] data;
    logic [3:0]  data_ch;
    logic        valid;
    logic        err;
    logic        busy;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic        int_auto;
    int          int_delay;
    logic [15:0] slave_base;
    logic [23:0] last_cmd;
    int          slave_bits;

    always #5 clk = ~clk;

    aio20_scan_ctrl #(
        .CLK_DIV     (CLK_DIV),
        .CNVT_WIDTH  (CNVT_WIDTH),
        .INT_TIMEOUT (INT_TIMEOUT),
        .N_CH        (N_CH)
    ) dut (
        .AIO20_CLK          (clk),
        .AIO20_RST          (rst),
        .AIO20_EN           (en),
        .AIO20_SPI_CLK_OUT  (sclk),
        .AIO20_SPI_MOSI_OUT (mosi),
        .AIO20_SPI_MISO_IN  (miso),
        .AIO20_SPI_NSS_OUT  (nss),
        .AIO20_SPI_INT_IN   (int_n),
        .AIO20_CNVT_OUT     (cnvt),
        .AIO20_DATA         (data),
        .AIO20_DATA_CH      (data_ch),
        .AIO20_DATA_VALID   (valid),
        .AIO20_TIMEOUT_ERR  (err),
        .AIO20_BUSY         (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_cnvt"},  32'(cnvt),    32'd0);
        check_eq({tag, "_nss"},   32'(nss),     32'd1);
        check_eq({tag, "_sclk"},  32'(sclk),    32'd0);
        check_eq({tag, "_mosi"},  32'(mosi),    32'd0);
        check_eq({tag, "_data"},  32'(data),    32'd0);
        check_eq({tag, "_ch"},    32'(data_ch), 32'd0);
        check_eq({tag, "_valid"}, 32'(valid),   32'd0);
        check_eq({tag, "_err"},   32'(err),     32'd0);
        check_eq({tag, "_busy"},  32'(busy),    32'd0);
    endtask

    task automatic wait_cnvt_high(input string tag);
        int n = 0;
        while (cnvt !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        check_eq(tag, 32'(cnvt), 32'd1);
    endtask

    task automatic wait_cnvt_low(input string tag);
        int n = 0;
        while (cnvt !== 1'b0 && n < 200) begin @(negedge clk); n++; end
        check_eq(tag, 32'(cnvt), 32'd0);
    endtask

    task automatic wait_nss_low(input string tag);
        int n = 0;
        while (nss !== 1'b0 && n < 200) begin @(negedge clk); n++; end
        check_eq(tag, 32'(nss), 32'd0);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (valid !== 1'b1 && n < 400) begin @(negedge clk); n++; end
        check_eq(tag, 32'(valid), 32'd1);
    endtask

    task automatic wait_busy_low(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 400) begin @(negedge clk); n++; end
        check_eq(tag, 32'(busy), 32'd0);
    endtask

    // Module INT: drops int_delay falling clock edges after CNVT ends, released when NSS falls.
    initial begin : int_responder
        int_n = 1'b1;
        forever begin
            @(negedge cnvt);
            if (int_auto) begin
                repeat (int_delay) @(negedge clk);
                int_n = 1'b0;
                @(negedge nss or posedge rst);
                int_n = 1'b1;
            end
        end
    end

    // SPI slave, mode 0: captures MOSI on SCLK rise, drives the next MISO bit after SCLK fall.
    initial begin : spi_slave
        logic [23:0] rx_cmd;
        logic [15:0] smp;
        miso       = 1'b0;
        last_cmd   = 24'h000000;
        slave_bits = 0;
        forever begin
            @(negedge nss);
            rx_cmd     = 24'h000000;
            smp        = 16'h0000;
            slave_bits = 0;
            miso       = 1'b0;
            for (int i = 0; i < 24; i++) begin
                @(posedge sclk or posedge nss);
                if (nss) break;
                rx_cmd     = {rx_cmd[22:0], mosi};
                slave_bits = i + 1;
                @(negedge sclk or posedge nss);
                if (nss) break;
                if (i == 7) smp = slave_base + {12'h000, rx_cmd[3:0]};
                if (i >= 7 && i < 23) miso = smp[22-i];
            end
            last_cmd = rx_cmd;
            miso     = 1'b0;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int       n;
        int       nv;
        logic     flag_a;
        logic     flag_b;
        logic [3:0] kc;

        rst        = 1'b1;
        en         = 1'b0;
        int_auto   = 1'b0;
        int_delay  = 1;
        slave_base = 16'hA5C3;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);

        // Single sample on channel 0.
        int_auto = 1'b1;
        int_delay = 1;
        en = 1'b1;
        wait_cnvt_high("single_cnvt_rise");
        n = 0;
        while (cnvt === 1'b1 && n < 50) begin n++; @(negedge clk); end
        check_eq("cnvt_width", 32'(n), 32'(CNVT_WIDTH));
        en = 1'b0;
        n = 0;
        while (nss === 1'b1 && n < 20) begin @(negedge clk); n++; end
        check_eq("int_to_nss_clocks", 32'(n), 32'd3);
        n = 0;
        while (nss === 1'b0 && n < 500) begin n++; @(negedge clk); end
        check_eq("nss_low_clocks", 32'(n), 32'd98);
        n = 0;
        while (valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        check_eq("nss_to_valid_clocks", 32'(n), 32'(CLK_DIV + 1));
        check_eq("single_data", 32'(data), 32'h0000A5C3);
        check_eq("single_ch", 32'(data_ch), 32'd0);
        check_eq("single_busy_low", 32'(busy), 32'd0);
        check_eq("single_mosi_frame", 32'(last_cmd), 32'h00800000);
        @(negedge clk);
        check_eq("valid_one_cycle", 32'(valid), 32'd0);

        // Scan wrap over three channels, then drop EN in the middle of the fourth frame.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        slave_base = 16'h1000;
        en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            kc = 4'(k);
            wait_valid("wrap_valid");
            check_eq("wrap_ch", 32'(data_ch), 32'(k));
            check_eq("wrap_data", 32'(data), 32'h1000 + 32'(k));
            check_eq("wrap_cmd", 32'(last_cmd), 32'({4'h8, kc, 16'h0000}));
            @(negedge clk);
        end
        wait_nss_low("wrap4_nss_low");
        repeat (20) @(negedge clk);
        en = 1'b0;
        n  = 0;
        nv = 0;
        while (n < 400) begin
            if (valid === 1'b1) nv++;
            if (busy === 1'b0) break;
            @(negedge clk);
            n++;
        end
        check_eq("endrop_busy_low", 32'(busy), 32'd0);
        check_eq("endrop_valid_count", 32'(nv), 32'd1);
        check_eq("endrop_ch", 32'(data_ch), 32'd0);
        check_eq("endrop_data", 32'(data), 32'h00001000);
        n = 0;
        repeat (50) begin
            @(negedge clk);
            if (cnvt === 1'b1) n++;
        end
        check_eq("endrop_no_cnvt", 32'(n), 32'd0);

        // INT never arrives: timeout on channel 1, next frame is channel 2.
        int_auto = 1'b0;
        en = 1'b1;
        wait_cnvt_high("tmo_cnvt_rise");
        wait_cnvt_low("tmo_cnvt_fall");
        n = 0;
        flag_a = 1'b0;
        while (err !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
            if (nss !== 1'b1) flag_a = 1'b1;
        end
        check_eq("tmo_err_clocks", 32'(n), 32'(INT_TIMEOUT));
        int_auto = 1'b1;
        int_delay = 1;
        @(negedge clk);
        check_eq("tmo_err_one_cycle", 32'(err), 32'd0);
        n = 0;
        flag_b = 1'b0;
        while (cnvt !== 1'b1 && n < 50) begin
            if (nss !== 1'b1) flag_a = 1'b1;
            if (valid === 1'b1) flag_b = 1'b1;
            @(negedge clk);
            n++;
        end
        check_eq("tmo_no_nss", 32'(flag_a), 32'd0);
        check_eq("tmo_no_valid", 32'(flag_b), 32'd0);
        wait_nss_low("tmo_next_nss_low");
        en = 1'b0;
        wait_valid("tmo_next_valid");
        check_eq("tmo_next_ch", 32'(data_ch), 32'd2);
        check_eq("tmo_next_data", 32'(data), 32'h00001002);
        check_eq("tmo_next_cmd", 32'(last_cmd), 32'h00820000);
        wait_busy_low("tmo_busy_low");

        // INT reaches the synchronizer output in the very clock the timeout count is reached.
        int_auto = 1'b1;
        int_delay = 13;
        en = 1'b1;
        wait_cnvt_high("edge_cnvt_rise");
        wait_cnvt_low("edge_cnvt_fall");
        n = 0;
        flag_a = 1'b0;
        while (nss === 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
            if (err === 1'b1) flag_a = 1'b1;
        end
        check_eq("edge_setup_clocks", 32'(n), 32'd15);
        check_eq("edge_no_err", 32'(flag_a), 32'd0);
        en = 1'b0;
        wait_valid("edge_valid");
        check_eq("edge_ch", 32'(data_ch), 32'd0);
        check_eq("edge_data", 32'(data), 32'h00001000);
        wait_busy_low("edge_busy_low");

        // Reset in the middle of a channel-1 frame.
        int_delay = 1;
        en = 1'b1;
        n = 0;
        while (slave_bits != 10 && n < 400) begin @(negedge clk); n++; end
        check_eq("rst_reach_bit10", 32'(slave_bits), 32'd10);
        check_eq("rst_sclk_high_before", 32'(sclk), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check_reset_values("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        wait_valid("rst_next_valid");
        check_eq("rst_next_ch", 32'(data_ch), 32'd0);
        check_eq("rst_next_data", 32'(data), 32'h00001000);
        en = 1'b0;
        wait_busy_low("rst_busy_low");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
